// File: rtl/spi_output_frame.sv
// spi_output_frame: SPI frame transmitter with active-low chip select, per-byte dc flag,
// selectable bit order and a programmable idle gap between frames.
module spi_output_frame #(
  parameter int NUM_BYTES  = 5,
  parameter bit LSB_FIRST  = 1'b0,
  parameter int GAP_CYCLES = 2,
  parameter bit IDLE_MOSI  = 1'b0
) (
  input  logic                   sclk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NUM_BYTES-1:0] in_bytes,
  input  logic [NUM_BYTES-1:0]   in_dc,
  output logic                   mosi,
  output logic                   cs_n,
  output logic                   dc,
  output logic                   busy,
  output logic                   done
);
  localparam int NB = 8 * NUM_BYTES;
  localparam int CW = $clog2(NB);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t               state_q, state_d;
  logic [NB-1:0]        sh_q, sh_d;
  logic [NUM_BYTES-1:0] dcr_q, dcr_d;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_nx;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 mosi_q, mosi_d, cs_n_q, cs_n_d, dc_q, dc_d, done_q, done_d;

  // sh_q and dcr_q hold only what is still to be sent; the next bit/flag sits at the output end
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    dcr_d   = dcr_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    dc_d    = dc_q;
    done_d  = 1'b0;
    cnt_nx  = cnt_q + 1'b1;
    if (state_q == IDLE) begin
      if (in_valid) begin
        state_d = SHIFT;
        cs_n_d  = 1'b0;
        cnt_d   = '0;
        mosi_d  = LSB_FIRST ? in_bytes[0] : in_bytes[NB-1];
        sh_d    = LSB_FIRST ? in_bytes >> 1 : in_bytes << 1;
        dc_d    = LSB_FIRST ? in_dc[0] : in_dc[NUM_BYTES-1];
        dcr_d   = LSB_FIRST ? in_dc >> 1 : in_dc << 1;
      end
    end else if (state_q == SHIFT) begin
      if (cnt_q == CNT_LAST) begin
        state_d = GAP_CYCLES > 0 ? GAP : IDLE;
        cs_n_d  = 1'b1;
        mosi_d  = IDLE_MOSI;
        dc_d    = 1'b0;
        done_d  = 1'b1;
        gap_d   = '0;
      end else begin
        cnt_d  = cnt_nx;
        mosi_d = LSB_FIRST ? sh_q[0] : sh_q[NB-1];
        sh_d   = LSB_FIRST ? sh_q >> 1 : sh_q << 1;
        if (cnt_nx[2:0] == 3'd0) begin
          dc_d  = LSB_FIRST ? dcr_q[0] : dcr_q[NUM_BYTES-1];
          dcr_d = LSB_FIRST ? dcr_q >> 1 : dcr_q << 1;
        end
      end
    end else begin
      gap_d = gap_q + 1'b1;
      if (gap_q == GAP_LAST) state_d = IDLE;
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      dcr_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      mosi_q  <= IDLE_MOSI;
      cs_n_q  <= 1'b1;
      dc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      dcr_q   <= dcr_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      dc_q    <= dc_d;
      done_q  <= done_d;
    end
  end

  assign in_ready = state_q == IDLE;
  assign busy     = state_q != IDLE;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;
  assign dc       = dc_q;
  assign done     = done_q;
endmodule

// File: tb/tb_spi_output_frame.sv
// tb_spi_output_frame: scoreboard bench over three parameter sets (default, LSB-first/no gap, one byte).
module tb_spi_output_frame;
  logic sclk = 1'b0;
  int   pass_c = 0, tot_c = 0;
  always #5 sclk = ~sclk;

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int N  = g == 2 ? 1 : 5;
    localparam bit L  = g == 1;
    localparam int G  = g == 0 ? 2 : (g == 1 ? 0 : 1);
    localparam bit IM = g == 1;
    localparam int NB = 8 * N;
    localparam int RB = NB > 17 ? 17 : NB / 2;

    logic          rst, in_valid, in_ready, mosi, cs_n, dc, busy, done;
    logic [NB-1:0] in_bytes;
    logic [N-1:0]  in_dc;
    logic [1:0]    exp_q[$];
    int            cyc = 0, next_free = 0, cap_cyc = -1;
    bit            fin = 1'b0;

    spi_output_frame #(.NUM_BYTES(N), .LSB_FIRST(L), .GAP_CYCLES(G), .IDLE_MOSI(IM)) u_dut (
      .sclk(sclk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_bytes(in_bytes), .in_dc(in_dc), .mosi(mosi), .cs_n(cs_n),
      .dc(dc), .busy(busy), .done(done)
    );

    task automatic chk(input string name, input int act, input int exp);
      tot_c++;
      if (act == exp) pass_c++;
      else $display("FAIL cfg%0d %s: got %0d expected %0d (cycle %0d)", g, name, act, exp, cyc);
    endtask

    initial forever begin
      int k, b;
      @(posedge sclk);
      if (rst) begin
        exp_q.delete();
        next_free = 0;
      end else if (in_valid && cyc >= next_free) begin
        for (int i = 0; i < NB; i++) begin
          k = L ? i / 8 : N - 1 - i / 8;
          b = L ? i % 8 : 7 - i % 8;
          exp_q.push_back({in_bytes[8*k+b], in_dc[k]});
        end
        cap_cyc   = cyc + 1;
        next_free = cyc + 1 + NB + G;
      end
      cyc++;
    end

    initial begin
      bit pcs;
      int lowc;
      logic [1:0] e;
      pcs  = 1'b1;
      lowc = 0;
      forever begin
        @(negedge sclk);
        if (rst) begin
          pcs  = 1'b1;
          lowc = 0;
        end else begin
          chk("in_ready", int'(in_ready), int'(cyc >= next_free));
          chk("busy", int'(busy), int'(cyc < next_free));
          if (!cs_n) begin
            if (pcs) begin
              chk("start_latency", cyc, cap_cyc);
              lowc = 0;
            end
            lowc++;
            chk("bits_pending", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              chk("mosi", int'(mosi), int'(e[1]));
              chk("dc", int'(dc), int'(e[0]));
            end
            chk("done_in_frame", int'(done), 0);
          end else begin
            chk("idle_mosi", int'(mosi), int'(IM));
            chk("idle_dc", int'(dc), 0);
            if (!pcs) begin
              chk("cs_low_len", lowc, NB);
              chk("done_pulse", int'(done), 1);
            end else chk("done_idle", int'(done), 0);
          end
          pcs = cs_n;
        end
      end
    end

    task automatic wait_idle();
      in_valid = 1'b0;
      repeat (NB + G + 4) @(negedge sclk);
    endtask

    task automatic one_frame(input logic [39:0] data, input logic [4:0] dcv);
      @(negedge sclk);
      in_bytes = NB'(data);
      in_dc    = N'(dcv);
      in_valid = 1'b1;
      @(negedge sclk);
      in_valid = 1'b0;
      in_bytes = NB'({$urandom, $urandom});
      in_dc    = N'($urandom);
    endtask

    initial begin
      rst = 1'b1; in_valid = 1'b0; in_bytes = '0; in_dc = '0;
      #1;
      chk("reset_cs_n", int'(cs_n), 1);
      chk("reset_mosi", int'(mosi), int'(IM));
      chk("reset_busy", int'(busy), 0);
      chk("reset_ready", int'(in_ready), 1);
      repeat (2) @(negedge sclk);
      rst = 1'b0;
      one_frame(40'h8B9BABCBEB, 5'b00000);
      wait_idle();
      one_frame(40'h8B9BABCBEB, 5'b10100);
      wait_idle();
      for (int i = 0; i < 300; i++) begin
        @(negedge sclk);
        in_valid = $urandom_range(0, 3) != 0;
        in_bytes = NB'({$urandom, $urandom});
        in_dc    = N'($urandom);
      end
      for (int i = 0; i < 150; i++) begin
        @(negedge sclk);
        in_valid = 1'b1;
        in_bytes = NB'({$urandom, $urandom});
        in_dc    = N'($urandom);
      end
      wait_idle();
      @(negedge sclk);
      in_bytes = NB'({$urandom, $urandom});
      in_valid = 1'b1;
      @(posedge sclk);
      #1 in_valid = 1'b0;
      repeat (RB) @(posedge sclk);
      #2 chk("pre_rst_cs_n", int'(cs_n), 0);
      #1 rst = 1'b1;
      #1;
      chk("rst_cs_n", int'(cs_n), 1);
      chk("rst_mosi", int'(mosi), int'(IM));
      chk("rst_busy", int'(busy), 0);
      chk("rst_ready", int'(in_ready), 1);
      chk("rst_done", int'(done), 0);
      repeat (2) @(negedge sclk);
      rst = 1'b0;
      one_frame(40'hC3A5_5A3C_E1, 5'b01011);
      wait_idle();
      chk("queue_drained", exp_q.size(), 0);
      fin = 1'b1;
    end
  end

  initial begin
    bit all_fin;
    all_fin = 1'b0;
    for (int i = 0; i < 20000 && !all_fin; i++) begin
      @(posedge sclk);
      all_fin = cfg[0].fin && cfg[1].fin && cfg[2].fin;
    end
    tot_c++;
    if (all_fin) pass_c++;
    else $display("FAIL timeout: stimulus finished %0d, required 1", all_fin);
    $display("%0d/%0d checks passed", pass_c, tot_c);
    $finish;
  end
endmodule
